// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, tx state encoding and time-to-cycle helper for the PS/2 host.
package ps2_pkg;
   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;
   typedef enum logic [2:0] {TX_IDLE, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_WAITHI} tx_state_t;
   function automatic int unsigned us2cyc(input int unsigned hz, input int unsigned us);
      return 32'((64'(hz) * 64'(us) + 64'd999_999) / 64'd1_000_000);
   endfunction
endpackage

// File: rtl/ps2_host_if.sv
// ps2_host_if: key-event, raw-byte and transmit handshake between the PS/2 host and its user.
interface ps2_host_if;
   logic strb, make, ext, rxstrb, ferr, txreq, txbusy, txdone, txerr;
   logic [7:0] code, rxbyte, txdata;
   modport master (input strb, make, ext, code, rxstrb, rxbyte, ferr, txbusy, txdone, txerr,
                   output txreq, txdata);
   modport slave (output strb, make, ext, code, rxstrb, rxbyte, ferr, txbusy, txdone, txerr,
                  input txreq, txdata);
endinterface

// File: rtl/ps2_filter.sv
// ps2_filter: synchronises both PS/2 lines, debounces the clock line and flags its falling edges.
module ps2_filter #(
   parameter int FILTER = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] pins,
   output logic       sclk,
   output logic       sdat,
   output logic       fall
);
   logic [1:0] s1, s2;
   logic [FILTER-1:0] sh;
   logic filt, nxt;
   assign sclk = s2[0];
   assign sdat = s2[1];
   // filtered level only moves once the whole window agrees
   assign nxt = &sh ? 1'b1 : ~|sh ? 1'b0 : filt;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         s1   <= 2'b11;
         s2   <= 2'b11;
         sh   <= '1;
         filt <= 1'b1;
         fall <= 1'b0;
      end else begin
         s1   <= pins;
         s2   <= s1;
         sh   <= {sh[FILTER-2:0], s2[0]};
         filt <= nxt;
         fall <= filt & ~nxt;
      end
endmodule

// File: rtl/ps2_host.sv
// ps2_host: PS/2 keyboard host; receives and decodes key events, sends command bytes to the device.
module ps2_host
   import ps2_pkg::*;
#(
   parameter int unsigned CLKHZ      = 28_000_000,
   parameter int          FILTER     = 8,
   parameter int unsigned INHIBIT_US = 120,
   parameter int unsigned RXTOUT_US  = 1000,
   parameter int unsigned TXTOUT_US  = 15000
) (
   input logic           clock,
   input logic           reset,
   inout wire [1:0]      ps2,
   ps2_host_if.slave     bus
);
   localparam int unsigned INH = us2cyc(CLKHZ, INHIBIT_US);
   localparam int unsigned RXT = us2cyc(CLKHZ, RXTOUT_US);
   localparam int unsigned TXT = us2cyc(CLKHZ, TXTOUT_US);
   localparam int IW = $clog2(INH + 1);
   localparam int RW = $clog2(RXT + 1);
   localparam int TW = $clog2(TXT + 1);

   logic sclk, sdat, fall;
   logic [3:0] cnt, idx;
   logic [7:0] sh;
   logic pbit, pend_ext, pend_brk, done_n, err_n;
   logic [RW-1:0] rtmr;
   logic [IW-1:0] itmr;
   logic [TW-1:0] wd;
   logic [9:0] txsh;
   tx_state_t state, nxt;

   ps2_filter #(.FILTER(FILTER)) u_filter (
      .clock(clock), .reset(reset), .pins(ps2), .sclk(sclk), .sdat(sdat), .fall(fall)
   );

   assign ps2[0] = state == TX_INHIBIT ? 1'b0 : 1'bz;
   assign ps2[1] = (state == TX_REQ || (state == TX_BITS && !txsh[idx])) ? 1'b0 : 1'bz;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt        <= '0;
         sh         <= '0;
         pbit       <= 1'b0;
         rtmr       <= '0;
         bus.rxstrb <= 1'b0;
         bus.rxbyte <= '0;
         bus.ferr   <= 1'b0;
      end else begin
         bus.rxstrb <= 1'b0;
         bus.ferr   <= 1'b0;
         if (state != TX_IDLE) begin
            cnt  <= '0;
            rtmr <= '0;
         end else if (fall) begin
            rtmr <= '0;
            if (cnt == 4'd10) begin
               cnt <= '0;
               if (sdat && (^sh ^ pbit)) begin
                  bus.rxstrb <= 1'b1;
                  bus.rxbyte <= sh;
               end else
                  bus.ferr <= 1'b1;
            end else if (cnt == 4'd9) begin
               pbit <= sdat;
               cnt  <= cnt + 1'b1;
            end else begin
               if (cnt != 4'd0) sh <= {sdat, sh[7:1]};
               if (cnt != 4'd0 || !sdat) cnt <= cnt + 1'b1;
            end
         end else if (cnt != 4'd0) begin
            if (rtmr == RW'(RXT - 1)) begin
               bus.ferr <= 1'b1;
               cnt      <= '0;
               rtmr     <= '0;
            end else
               rtmr <= rtmr + 1'b1;
         end
      end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         pend_ext <= 1'b0;
         pend_brk <= 1'b0;
         bus.strb <= 1'b0;
         bus.make <= 1'b0;
         bus.ext  <= 1'b0;
         bus.code <= '0;
      end else begin
         bus.strb <= 1'b0;
         if (bus.ferr) begin
            pend_ext <= 1'b0;
            pend_brk <= 1'b0;
         end else if (bus.rxstrb) begin
            if (bus.rxbyte == PFX_EXT)
               pend_ext <= 1'b1;
            else if (bus.rxbyte == PFX_BRK)
               pend_brk <= 1'b1;
            else begin
               bus.strb <= 1'b1;
               bus.code <= bus.rxbyte;
               bus.make <= !pend_brk;
               bus.ext  <= pend_ext;
               pend_ext <= 1'b0;
               pend_brk <= 1'b0;
            end
         end
      end

   always_comb begin
      nxt    = state;
      done_n = 1'b0;
      err_n  = 1'b0;
      case (state)
         TX_IDLE:    if (bus.txbusy && cnt == 4'd0 && !bus.rxstrb && !bus.ferr) nxt = TX_INHIBIT;
         TX_INHIBIT: if (itmr == IW'(INH - 1)) nxt = TX_REQ;
         TX_REQ:     if (fall) nxt = TX_BITS;
         TX_BITS:    if (fall && idx == 4'd8) nxt = TX_ACK;
         TX_ACK:     if (fall) begin
            nxt   = sdat ? TX_IDLE : TX_WAITHI;
            err_n = sdat;
         end
         TX_WAITHI:  if (sclk && sdat) begin
            nxt    = TX_IDLE;
            done_n = 1'b1;
         end
         default:    nxt = TX_IDLE;
      endcase
      // watchdog overrides whatever the protocol step wanted
      if (state != TX_IDLE && wd == TW'(TXT - 1)) begin
         nxt    = TX_IDLE;
         done_n = 1'b0;
         err_n  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state      <= TX_IDLE;
         idx        <= '0;
         itmr       <= '0;
         wd         <= '0;
         txsh       <= '0;
         bus.txbusy <= 1'b0;
         bus.txdone <= 1'b0;
         bus.txerr  <= 1'b0;
      end else begin
         state      <= nxt;
         bus.txdone <= done_n;
         bus.txerr  <= err_n;
         itmr       <= state == TX_INHIBIT ? itmr + 1'b1 : '0;
         wd         <= state != TX_IDLE ? wd + 1'b1 : '0;
         idx        <= state == TX_BITS ? idx + {3'b000, fall} : '0;
         if (!bus.txbusy && bus.txreq) begin
            bus.txbusy <= 1'b1;
            txsh       <= {1'b1, ~^bus.txdata, bus.txdata};
         end else if (done_n || err_n)
            bus.txbusy <= 1'b0;
      end
endmodule
